// File: rtl/contact_group_distributor.sv
// contact_group_distributor: byte-command driven writer/reader for grouped tri-state contact pins
module contact_group_distributor #(
  parameter int unsigned NContacts  = 136,
  parameter int unsigned GroupWidth = 4,
  parameter int unsigned RxTimeout  = 65535
) (
  input  logic                 i_clock,
  input  logic                 i_nreset,
  input  logic [7:0]           i_data,
  input  logic                 i_data_valid,
  input  logic                 i_tx_full,
  inout  wire  [NContacts-1:0] io_data_to_contacts,
  output logic [7:0]           o_data_out,
  output logic                 o_wr_req,
  output logic                 o_busy,
  output logic [1:0]           o_status_led
);

  localparam int unsigned NGroups   = NContacts / GroupWidth;
  localparam int unsigned MaskBytes = (NGroups + 7) / 8;
  localparam int unsigned ReadBytes = (NContacts + 7) / 8;
  localparam int unsigned ReadW     = ReadBytes * 8;
  localparam int unsigned GrpW      = $clog2(NGroups + ReadBytes + 1);
  localparam int unsigned CntW      = $clog2(NContacts + 2);
  localparam int unsigned ToW       = $clog2(RxTimeout + 1);

  localparam logic [7:0] CmdFullWr = 8'h01;
  localparam logic [7:0] CmdFullRd = 8'h20;
  localparam logic [7:0] CmdMask   = 8'h40;
  localparam logic [7:0] CmdMaskWr = 8'h50;
  localparam logic [7:0] CmdMaskRd = 8'h60;
  localparam logic [7:0] CmdCheck  = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE, S_RX_FULL, S_RX_MASK, S_RX_MWR, S_LOAD, S_SNAP, S_TX, S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [NContacts-1:0] r_drv, r_z, r_sh_drv, r_sh_z;
  logic [NContacts-1:0] r_sync1, r_sync2, r_snap;
  logic [NGroups-1:0]   r_mask, r_sh_mask;
  logic [7:0]           r_code;
  logic [GrpW-1:0]      r_grp;
  logic [CntW-1:0]      r_left;
  logic [ToW-1:0]       r_to_cnt;
  logic                 r_first;
  logic [1:0]           r_led;

  logic [GrpW-1:0]      w_cur, w_wr_grp;
  logic [CntW-1:0]      w_mask_cnt;
  logic                 w_timeout;
  logic [NContacts-1:0] w_sh_drv_upd, w_sh_z_upd;
  logic [NGroups-1:0]   w_sh_mask_upd;
  logic [ReadW-1:0]     w_snap_pad;
  logic [7:0]           w_rd_byte, w_grp_byte, w_tx_byte;

  // Lowest set mask bit at or above 'from'; NGroups when none
  function automatic logic [GrpW-1:0] f_first_set(input logic [NGroups-1:0] m,
                                                  input logic [GrpW-1:0]    from);
    logic [GrpW-1:0] idx;
    idx = GrpW'(NGroups);
    for (int g = NGroups - 1; g >= 0; g--) begin
      if (m[g] && (GrpW'(g) >= from)) idx = GrpW'(g);
    end
    return idx;
  endfunction

  function automatic logic [CntW-1:0] f_popcount(input logic [NGroups-1:0] m);
    logic [CntW-1:0] n;
    n = '0;
    for (int g = 0; g < NGroups; g++) n = n + CntW'(m[g]);
    return n;
  endfunction

  // Pin drivers: released to Z where the Z register bit is set
  for (genvar i = 0; i < NContacts; i++) begin : g_pin
    assign io_data_to_contacts[i] = r_z[i] ? 1'bz : r_drv[i];
  end

  assign w_cur      = f_first_set(r_mask, r_grp);
  assign w_mask_cnt = f_popcount(r_mask);
  assign w_timeout  = (r_to_cnt == ToW'(RxTimeout - 1));
  assign w_wr_grp   = (r_state == S_RX_MWR) ? w_cur : r_grp;
  assign w_snap_pad = ReadW'(r_snap);
  assign w_rd_byte  = w_snap_pad[{r_grp, 3'b000} +: 8];
  assign w_tx_byte  = r_first ? r_code : ((r_code == CmdFullRd) ? w_rd_byte : w_grp_byte);
  assign o_status_led = r_led;

  // Shadow updates for the incoming payload byte and masked-read group selection
  always_comb begin
    w_sh_drv_upd  = r_sh_drv;
    w_sh_z_upd    = r_sh_z;
    w_sh_mask_upd = r_sh_mask;
    w_grp_byte    = '0;
    for (int g = 0; g < NGroups; g++) begin
      if (GrpW'(g) == w_wr_grp) begin
        w_sh_drv_upd[g*GroupWidth +: GroupWidth] = i_data[GroupWidth-1:0];
        w_sh_z_upd[g*GroupWidth +: GroupWidth]   = i_data[4 +: GroupWidth];
      end
      if (GrpW'(g / 8) == r_grp) w_sh_mask_upd[g] = i_data[g % 8];
      if (GrpW'(g) == w_cur) w_grp_byte = 8'(r_snap[g*GroupWidth +: GroupWidth]);
    end
  end

  // State register
  always_ff @(posedge i_clock or negedge i_nreset) begin
    if (!i_nreset) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (i_data_valid) begin
          case (i_data)
            CmdFullWr:            w_state_nxt = S_RX_FULL;
            CmdFullRd, CmdMaskRd: w_state_nxt = S_SNAP;
            CmdMask:              w_state_nxt = S_RX_MASK;
            CmdMaskWr:            w_state_nxt = (w_mask_cnt == '0) ? S_LOAD : S_RX_MWR;
            CmdCheck:             w_state_nxt = S_TX;
            default:              w_state_nxt = S_IDLE;
          endcase
        end
      end
      S_RX_FULL, S_RX_MASK, S_RX_MWR: begin
        if (i_data_valid) begin
          if (r_left == CntW'(1)) w_state_nxt = S_LOAD;
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOAD:  w_state_nxt = S_TX;
      S_SNAP:  w_state_nxt = S_TX;
      S_TX:    if (!i_tx_full && (r_left == CntW'(1))) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Two-flop pin synchroniser and readback snapshot
  always_ff @(posedge i_clock or negedge i_nreset) begin
    if (!i_nreset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_snap  <= '0;
    end else begin
      r_sync1 <= io_data_to_contacts;
      r_sync2 <= r_sync1;
      if (r_state == S_SNAP) r_snap <= r_sync2;
    end
  end

  // Command datapath: payload capture, atomic loads, transmit sequencing
  always_ff @(posedge i_clock or negedge i_nreset) begin
    if (!i_nreset) begin
      r_drv      <= '0;
      r_z        <= '1;
      r_mask     <= '0;
      r_sh_drv   <= '0;
      r_sh_z     <= '1;
      r_sh_mask  <= '0;
      r_code     <= '0;
      r_grp      <= '0;
      r_left     <= '0;
      r_to_cnt   <= '0;
      r_first    <= 1'b0;
      r_led      <= 2'b01;
      o_data_out <= '0;
      o_wr_req   <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      o_wr_req <= 1'b0;
      o_busy   <= (w_state_nxt != S_IDLE);
      unique case (r_state)
        S_IDLE: begin
          if (w_state_nxt != S_IDLE) begin
            r_code    <= i_data;
            r_grp     <= '0;
            r_to_cnt  <= '0;
            r_first   <= 1'b1;
            r_sh_drv  <= r_drv;
            r_sh_z    <= r_z;
            r_sh_mask <= r_mask;
            r_left    <= CntW'(1);
            if (i_data == CmdFullWr) r_left <= CntW'(NGroups);
            if (i_data == CmdMask)   r_left <= CntW'(MaskBytes);
            if (i_data == CmdMaskWr) r_left <= w_mask_cnt;
            if (i_data == CmdCheck)  r_led[1] <= 1'b1;
          end
        end
        S_RX_FULL, S_RX_MASK, S_RX_MWR: begin
          if (i_data_valid) begin
            r_to_cnt <= '0;
            r_left   <= r_left - CntW'(1);
            if (r_state == S_RX_MASK) begin
              r_sh_mask <= w_sh_mask_upd;
            end else begin
              r_sh_drv <= w_sh_drv_upd;
              r_sh_z   <= w_sh_z_upd;
            end
            r_grp <= (r_state == S_RX_MWR) ? w_cur + GrpW'(1) : r_grp + GrpW'(1);
          end else begin
            r_to_cnt <= w_timeout ? '0 : r_to_cnt + ToW'(1);
          end
        end
        S_LOAD: begin
          if (r_code == CmdMask) begin
            r_mask <= r_sh_mask;
          end else begin
            r_drv <= r_sh_drv;
            r_z   <= r_sh_z;
          end
          r_left <= CntW'(1);
        end
        S_SNAP: begin
          r_grp  <= '0;
          r_left <= (r_code == CmdFullRd) ? CntW'(ReadBytes + 1) : w_mask_cnt + CntW'(1);
        end
        S_TX: begin
          if (!i_tx_full) begin
            o_wr_req   <= 1'b1;
            o_data_out <= w_tx_byte;
            r_first    <= 1'b0;
            r_left     <= r_left - CntW'(1);
            if (!r_first) begin
              r_grp <= (r_code == CmdFullRd) ? r_grp + GrpW'(1) : w_cur + GrpW'(1);
            end
          end
        end
        S_DONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_contact_group_distributor.sv
// Directed bench for contact_group_distributor (136 contacts, groups of 4, short rx timeout)
module tb_contact_group_distributor;

  localparam int unsigned NC = 136;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    data;
  logic          valid;
  logic          tx_full;
  wire  [NC-1:0] pins;
  logic [7:0]    data_out;
  logic          wr_req;
  logic          busy;
  logic [1:0]    led;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] tx_q[$];

  logic [NC-1:0] exp_full;
  logic [NC-1:0] exp_mdrv;
  logic [NC-1:0] exp_mz;

  contact_group_distributor #(
    .NContacts (136),
    .GroupWidth(4),
    .RxTimeout (16)
  ) dut (
    .i_clock            (clk),
    .i_nreset           (rst_n),
    .i_data             (data),
    .i_data_valid       (valid),
    .i_tx_full          (tx_full),
    .io_data_to_contacts(pins),
    .o_data_out         (data_out),
    .o_wr_req           (wr_req),
    .o_busy             (busy),
    .o_status_led       (led)
  );

  always #5 clk = ~clk;

  // Collect every transmitted byte (one per WrReq high cycle)
  always @(negedge clk) begin
    if (wr_req) tx_q.push_back(data_out);
  end

  task automatic check(input string tag, input logic [NC-1:0] obs, input logic [NC-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; presents one byte for exactly one rising edge
  task automatic send_byte(input logic [7:0] b);
    data  = b;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, NC'(busy), NC'(1'b0));
    repeat (2) @(negedge clk);
  endtask

  task automatic check_read55(input string tag);
    check({tag, "_cnt"}, NC'(tx_q.size()), NC'(18));
    if (tx_q.size() >= 18) begin
      check({tag, "_hdr"}, NC'(tx_q[0]), NC'(8'h20));
      for (int j = 1; j < 18; j++) check($sformatf("%s_b%0d", tag, j), NC'(tx_q[j]), NC'(8'h55));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  initial begin
    int n;
    int n0;
    exp_full = {34{4'h5}};
    exp_mdrv = {{32{4'h5}}, 4'h0, 4'hF};
    exp_mz   = NC'(8'hF0);
    rst_n = 1'b0; valid = 1'b0; data = '0; tx_full = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_wrreq", NC'(wr_req), NC'(1'b0));
    check("rst_busy",  NC'(busy),   NC'(1'b0));
    check("rst_led",   NC'(led),    NC'(2'b01));
    check("rst_z",     dut.r_z,     {NC{1'b1}});
    check("rst_drv",   dut.r_drv,   NC'(0));

    // Board check
    tx_q.delete();
    send_byte(8'hFF);
    wait_idle("chk");
    check("chk_cnt",  NC'(tx_q.size()), NC'(1));
    check("chk_byte", NC'(tx_q[0]),     NC'(8'hFF));
    check("chk_led",  NC'(led),         NC'(2'b11));

    // Unknown command is ignored
    send_byte(8'h77);
    check("unk_busy", NC'(busy), NC'(1'b0));
    repeat (3) @(negedge clk);
    check("unk_tx", NC'(tx_q.size()), NC'(1));

    // Full write: nothing moves until the cycle after the 34th byte
    tx_q.delete();
    send_byte(8'h01);
    for (int k = 0; k < 33; k++) send_byte(8'h05);
    check("fw_pre33", dut.r_drv, NC'(0));
    send_byte(8'h05);
    check("fw_pre_load", dut.r_drv, NC'(0));
    @(negedge clk);
    check("fw_pins", pins,    exp_full);
    check("fw_z",    dut.r_z, NC'(0));
    wait_idle("fw");
    check("fw_cnt", NC'(tx_q.size()), NC'(1));
    check("fw_ack", NC'(tx_q[0]),     NC'(8'h01));

    // Full read of looped-back pins
    tx_q.delete();
    send_byte(8'h20);
    wait_idle("fr");
    check_read55("fr");

    // Full read with TxFull held mid-stream
    tx_q.delete();
    send_byte(8'h20);
    n = 0;
    while (tx_q.size() < 5 && n < 100) begin
      @(negedge clk); #1; n++;
    end
    tx_full = 1'b1;
    n0 = tx_q.size();
    repeat (10) begin
      @(negedge clk); #1;
    end
    check("hold_no_wr", NC'(tx_q.size()), NC'(n0));
    check("hold_busy",  NC'(busy),        NC'(1'b1));
    tx_full = 1'b0;
    @(negedge clk);
    wait_idle("hold");
    check_read55("hold");

    // Mask groups 0,1; out-of-range bits in the last byte are ignored
    tx_q.delete();
    send_byte(8'h40);
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'hFC);
    wait_idle("mk");
    check("mk_ack",  NC'(tx_q[0]),   NC'(8'h40));
    check("mk_mask", NC'(dut.r_mask), NC'(34'h3));

    // Masked write
    tx_q.delete();
    send_byte(8'h50); send_byte(8'h0F); send_byte(8'hF0);
    wait_idle("mw");
    check("mw_cnt",  NC'(tx_q.size()), NC'(1));
    check("mw_ack",  NC'(tx_q[0]),     NC'(8'h50));
    check("mw_drv",  dut.r_drv,        exp_mdrv);
    check("mw_z",    dut.r_z,          exp_mz);
    check("mw_lo",   NC'(pins[3:0]),   NC'(4'hF));
    check("mw_hi",   NC'(pins[NC-1:8]), NC'({32{4'h5}}));

    // Masked read
    tx_q.delete();
    send_byte(8'h60);
    wait_idle("mr");
    check("mr_cnt", NC'(tx_q.size()), NC'(3));
    check("mr_hdr", NC'(tx_q[0]),     NC'(8'h60));
    check("mr_g0",  NC'(tx_q[1]),     NC'(8'h0F));

    // Empty mask
    tx_q.delete();
    send_byte(8'h40);
    for (int k = 0; k < 5; k++) send_byte(8'h00);
    wait_idle("em");
    check("em_mask", NC'(dut.r_mask), NC'(0));
    tx_q.delete();
    send_byte(8'h50);
    wait_idle("emw");
    check("emw_cnt", NC'(tx_q.size()), NC'(1));
    check("emw_ack", NC'(tx_q[0]),     NC'(8'h50));
    check("emw_drv", dut.r_drv,        exp_mdrv);
    tx_q.delete();
    send_byte(8'h60);
    wait_idle("emr");
    check("emr_cnt", NC'(tx_q.size()), NC'(1));
    check("emr_hdr", NC'(tx_q[0]),     NC'(8'h60));

    // Receive timeout: 15 silent cycles still busy, 16 abandon the command
    tx_q.delete();
    send_byte(8'h01);
    for (int k = 0; k < 5; k++) send_byte(8'h33);
    repeat (15) @(negedge clk);
    check("to_busy15", NC'(busy), NC'(1'b1));
    repeat (3) @(negedge clk);
    check("to_idle", NC'(busy), NC'(1'b0));
    repeat (3) @(negedge clk);
    check("to_noack", NC'(tx_q.size()), NC'(0));
    check("to_drv",   dut.r_drv,        exp_mdrv);
    check("to_z",     dut.r_z,          exp_mz);

    // Async reset mid-payload
    send_byte(8'h01);
    for (int k = 0; k < 3; k++) send_byte(8'h11);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_z",    dut.r_z,     {NC{1'b1}});
    check("ar_drv",  dut.r_drv,   NC'(0));
    check("ar_busy", NC'(busy),   NC'(1'b0));
    check("ar_led",  NC'(led),    NC'(2'b01));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("ar_post_busy", NC'(busy), NC'(1'b0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/contact_group_distributor.md
# contact_group_distributor

Parametrised command-driven contact driver and reader for the DevBD board, sitting between the host byte link (receive stream in, transmit FIFO out) and the bidirectional contact pins. It extends full-bank write/read and board check with group masks, masked write and masked read. It also adds transmit back-pressure, a receive timeout, async reset and synchronised pin readback. Each pin is independently driven 0/1 or released to Z.

## Interface
- NContacts, 136, number of contact pins; must be a multiple of GroupWidth.
- GroupWidth, 4, contacts per group, 1..4; NGroups = NContacts/GroupWidth, MaskBytes = ceil(NGroups/8), ReadBytes = ceil(NContacts/8).
- RxTimeout, 65535, idle cycles allowed between payload bytes before a command is abandoned; ≥2.
- Clock  in  1  system clock, all logic on rising edge.
- nReset  in  1  asynchronous, active-low reset.
- Data  in  8  received byte.
- DataValid  in  1  Data valid this cycle; one byte per high cycle.
- TxFull  in  1  transmit FIFO full; no write may be issued while sampled high.
- DataToContacts  inout  NContacts  contact pins; bit i = Z when ZReg[i], else DrvReg[i].
- DataOut  out  8  transmit byte, valid when WrReq high.
- WrReq  out  1  one-cycle write strobe per transmitted byte.
- Busy  out  1  high whenever FSM not IDLE.
- StatusLED  out  2  [0] alive, [1] board-check seen.

## Operation
- Reset values: DrvReg all 0, ZReg all 1 (every pin Z), Mask all 0, DataOut 0, WrReq 0, Busy 0, StatusLED 2'b01, FSM IDLE, timeout counter 0.
- Group byte format: bits[GroupWidth-1:0] drive levels, bits[4+GroupWidth-1:4] Z enables (1 = Z), LSB = lowest contact of group; other bits ignored on receive, 0 on transmit.
- Pin readback passes a 2-flop synchroniser; "sample" = synchronised value captured into a snapshot register in one cycle.
- IDLE decodes Data when DataValid; unknown codes ignored, stay IDLE.
- 0x01 full write: receive NGroups bytes, byte k → group k; shadow registers only. After last byte, DrvReg/ZReg load together, then transmit ack 0x01.
- 0x20 full read: snapshot all pins, transmit 0x20, then ReadBytes bytes, byte j = contacts 8j..8j+7 (bit 0 lowest), pad bits beyond NContacts = 0.
- 0x40 set mask: receive MaskBytes bytes, byte j bit b → group 8j+b, bits ≥ NGroups ignored; mask updates after last byte; ack 0x40.
- 0x50 masked write: receive one byte per set mask bit, ascending group order; unmasked groups keep previous values; atomic load after last byte; ack 0x50. Empty mask → no payload expected, ack 0x50 immediately.
- 0x60 masked read: snapshot, transmit 0x60, then one byte per masked group ascending: bits[GroupWidth-1:0] pin levels, rest 0. Empty mask → header only.
- 0xFF board check: StatusLED[1] ← 1, transmit 0xFF.
- Receive timeout: in any payload state, RxTimeout consecutive cycles without DataValid → return to IDLE, shadow discarded, DrvReg/ZReg/Mask unchanged, no ack.
- DataValid bytes arriving in transmit states are dropped.

## Timing
- Command byte sampled at edge t → FSM leaves IDLE at t, Busy high from t+1.
- Payload states accept one byte per DataValid cycle, back-to-back allowed; timeout counter clears on each accepted byte.
- Last payload byte at edge t → DrvReg/ZReg (or Mask) update at edge t+1, so pins change in the cycle after t+1. Ack byte is pending from t+1.
- Snapshot at edge after command byte (t+1). Pins must be stable ≥3 cycles before the command byte for guaranteed capture.
- Transmit: a pending byte is issued (WrReq=1, DataOut valid) on the cycle following an edge where TxFull sampled 0. WrReq is never high two cycles per byte. Back-to-back bytes are allowed while TxFull stays 0. TxFull high holds the byte and keeps WrReq 0 indefinitely (no timeout on transmit).
- Busy falls in the cycle after the last WrReq, or after the last update for a timed-out command. Next command is accepted the cycle Busy is low.
- Async reset mid-command: immediate return to reset values, pins go Z, partial shadow lost.

## Test plan
- Reset → all pins Z, WrReq 0, StatusLED=01. Send 0xFF with TxFull=0 → single WrReq with DataOut=0xFF, StatusLED=11.
- Defaults: 0x01 + 34 bytes 0x05 (drive 0101, Z 0000) → every group drives 0101 only after the 34th byte, then ack 0x01. Then 0x20 with pins looped back → 0x20 and 17 bytes of 0x55.
- 0x40, 0x03 then four 0x00 → mask groups 0,1. Then 0x50, 0x0F, 0xF0 → contacts 3:0 = 1111, 7:4 = Z, rest unchanged; ack 0x50. Then 0x60 → 0x60 plus 2 bytes.
- Empty mask: 0x50 → immediate ack 0x50, no pin change; 0x60 → header only.
- Hold TxFull=1 during a 0x20 reply for 10 cycles mid-stream → no WrReq while held, no byte lost or duplicated, 18 bytes total.
- RxTimeout=16: 0x01 then 5 bytes then 16 silent cycles → IDLE, pins unchanged, no ack. Async reset mid-payload → pins Z immediately.
